// File: rtl/tt_query_feeder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tt_query_feeder_if : host write, TT drive/result and host result signals |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface tt_query_feeder_if;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_data;
    logic       wr_last;
    logic       tt_in_valid;
    logic [3:0] tt_source;
    logic [3:0] tt_destination;
    logic       tt_out_valid;
    logic [3:0] tt_cost;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_cost;
    logic [7:0] res_qid;
    logic       res_trunc;
    logic       res_timeout;

    // Feeder side.
    modport slave (
        input  wr_valid, wr_data, wr_last, tt_out_valid, tt_cost, res_ready,
        output wr_ready, tt_in_valid, tt_source, tt_destination,
               res_valid, res_cost, res_qid, res_trunc, res_timeout
    );

    // Host and TT side.
    modport master (
        output wr_valid, wr_data, wr_last, tt_out_valid, tt_cost, res_ready,
        input  wr_ready, tt_in_valid, tt_source, tt_destination,
               res_valid, res_cost, res_qid, res_trunc, res_timeout
    );
endinterface
`default_nettype wire

// File: rtl/tt_query_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tt_query_feeder : buffers a host query, replays it to TT as a gap-free   |
// | burst and returns TT's cost (or a timeout) to the host. TIMEOUT >= 1.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tt_query_feeder #(
    parameter int DEPTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    tt_query_feeder_if.slave bus
);
    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_CNT_W  = c_ADDR_W + 1;
    localparam int c_TMR_W  = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH   = c_CNT_W'(DEPTH);
    localparam logic [c_TMR_W-1:0] c_TIMEOUT = c_TMR_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_SEND    = 2'd1,
        S_WAIT    = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_count;
    logic [c_CNT_W-1:0]  r_idx;
    logic [c_TMR_W-1:0]  r_timer;
    logic                r_trunc;
    logic [7:0]          r_qid;
    logic                r_wr_ready;
    logic                r_tt_in_valid;
    logic [3:0]          r_tt_source;
    logic [3:0]          r_tt_destination;
    logic                r_res_valid;
    logic [3:0]          r_res_cost;
    logic                r_res_trunc;
    logic                r_res_timeout;
    logic [7:0]          r_buf [DEPTH];

    logic                w_accept;
    logic                w_buf_wr;
    logic [7:0]          w_rd_beat;

    assign w_accept  = bus.wr_valid & r_wr_ready & (r_state == S_COLLECT);
    assign w_buf_wr  = w_accept & (r_count < c_DEPTH);
    assign w_rd_beat = r_buf[r_idx[c_ADDR_W-1:0]];

    // Beat storage carries no reset; r_count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_buf_wr) begin
            r_buf[r_count[c_ADDR_W-1:0]] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= S_COLLECT;
            r_count          <= '0;
            r_idx            <= '0;
            r_timer          <= '0;
            r_trunc          <= 1'b0;
            r_qid            <= '0;
            r_wr_ready       <= 1'b0;
            r_tt_in_valid    <= 1'b0;
            r_tt_source      <= '0;
            r_tt_destination <= '0;
            r_res_valid      <= 1'b0;
            r_res_cost       <= '0;
            r_res_trunc      <= 1'b0;
            r_res_timeout    <= 1'b0;
        end else begin
            case (r_state)
                S_COLLECT: begin
                    r_wr_ready <= 1'b1;
                    if (w_accept) begin
                        if (r_count < c_DEPTH) begin
                            r_count <= r_count + 1'b1;
                        end else begin
                            r_trunc <= 1'b1;
                        end
                        if (bus.wr_last) begin
                            r_wr_ready <= 1'b0;
                            r_idx      <= '0;
                            r_state    <= S_SEND;
                        end
                    end
                end
                S_SEND: begin
                    // One beat per cycle with no bubbles: TT leaves its read
                    // phase on the first idle cycle.
                    if (r_idx < r_count) begin
                        r_tt_in_valid    <= 1'b1;
                        r_tt_source      <= w_rd_beat[7:4];
                        r_tt_destination <= w_rd_beat[3:0];
                        r_idx            <= r_idx + 1'b1;
                    end else begin
                        r_tt_in_valid    <= 1'b0;
                        r_tt_source      <= '0;
                        r_tt_destination <= '0;
                        r_timer          <= '0;
                        r_state          <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // The strobe is tested first so it wins over expiry.
                    if (bus.tt_out_valid) begin
                        r_res_cost    <= bus.tt_cost;
                        r_res_timeout <= 1'b0;
                        r_res_trunc   <= r_trunc;
                        r_res_valid   <= 1'b1;
                        r_state       <= S_RESP;
                    end else if (r_timer == c_TIMEOUT) begin
                        r_res_cost    <= '0;
                        r_res_timeout <= 1'b1;
                        r_res_trunc   <= r_trunc;
                        r_res_valid   <= 1'b1;
                        r_state       <= S_RESP;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_RESP: begin
                    if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        r_qid       <= r_qid + 1'b1;
                        r_count     <= '0;
                        r_trunc     <= 1'b0;
                        r_wr_ready  <= 1'b1;
                        r_state     <= S_COLLECT;
                    end
                end
                default: begin
                    r_state <= S_COLLECT;
                end
            endcase
        end
    end

    assign bus.wr_ready       = r_wr_ready;
    assign bus.tt_in_valid    = r_tt_in_valid;
    assign bus.tt_source      = r_tt_source;
    assign bus.tt_destination = r_tt_destination;
    assign bus.res_valid      = r_res_valid;
    assign bus.res_cost       = r_res_cost;
    assign bus.res_qid        = r_qid;
    assign bus.res_trunc      = r_res_trunc;
    assign bus.res_timeout    = r_res_timeout;
endmodule
`default_nettype wire

// File: doc/tt_query_feeder.md
Name: tt_query_feeder

Overview:
- Upstream stage of the travel-time (TT) shortest-hop engine.
- Accepts a host query stream over a valid/ready handshake: beat 0 is the {source, destination} query, and each later beat is one undirected edge {a, b}.
- Buffers each complete query, then replays it to TT as one unbroken in_valid burst. TT exits its read phase on the first in_valid-low cycle, so the burst must not have gaps.
- Captures TT's cost result and returns it to the host over a second valid/ready handshake.

Parameters:
DEPTH, 32, beat buffer capacity per query (query beat plus up to DEPTH-1 edges); power of two, at least 2.
TIMEOUT, 64, maximum cycles to wait for tt_out_valid after the burst ends.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  asynchronous, active-high reset.
wr_valid  in  1  host beat valid.
wr_ready  out  1  feeder can accept a beat.
wr_data  in  8  [7:4] = source/a, [3:0] = destination/b.
wr_last  in  1  marks the final beat of a query.
tt_in_valid  out  1  drives TT in_valid.
tt_source  out  4  drives TT source.
tt_destination  out  4  drives TT destination.
tt_out_valid  in  1  TT result strobe.
tt_cost  in  4  TT cost; sampled only while tt_out_valid=1.
res_valid  out  1  result available.
res_ready  in  1  host accepts result.
res_cost  out  4  hop count (0 = unreachable or timeout).
res_qid  out  8  query sequence number; starts at 0 and wraps 255->0.
res_trunc  out  1  query exceeded DEPTH beats; extra beats were dropped.
res_timeout  out  1  TT gave no result within TIMEOUT cycles.

Behaviour:
- Reset:
  - State = COLLECT; buffer count = 0; qid = 0; trunc flag = 0.
  - wr_ready = 0 during reset and 1 on the first cycle after it.
  - tt_in_valid = 0, tt_source = 0, tt_destination = 0.
  - res_valid = 0, res_cost = 0, res_trunc = 0, res_timeout = 0.
  - Reset mid-query discards everything buffered. No partial burst may leave after reset.
- All outputs are registered.
- COLLECT:
  - wr_ready = 1. A beat is accepted when wr_valid && wr_ready.
  - Accepted beats are written at index count, and count increments.
  - When count == DEPTH, further beats are still accepted but discarded, and the trunc flag is set.
  - Accepting a beat with wr_last=1 moves to SEND on the next cycle.
  - A single-beat query (wr_last on beat 0) is legal.
- SEND:
  - wr_ready = 0.
  - Starting the cycle after entry, tt_in_valid=1 for exactly N consecutive cycles, where N = min(beats received, DEPTH).
  - Beat i appears in burst cycle i in the original order. tt_source = buffer[i][7:4] and tt_destination = buffer[i][3:0].
  - After the last beat: tt_in_valid=0, tt_source/tt_destination return to 0, and the state moves to WAIT.
  - The wait timer is cleared on entry to WAIT.
- WAIT:
  - Timer counts each cycle.
  - tt_out_valid=1 → latch tt_cost, res_timeout=0, go to RESP.
  - Timer reaching TIMEOUT with no strobe → res_cost=0, res_timeout=1, go to RESP.
  - If tt_out_valid and timer expiry occur in the same cycle, the strobe wins.
  - tt_out_valid seen in any state other than WAIT is ignored.
- RESP:
  - res_valid=1, and res_cost, res_qid, res_trunc, res_timeout are held stable until res_ready.
  - On the res_valid && res_ready cycle: qid increments (wrapping), count and trunc clear, and the state returns to COLLECT.
  - wr_ready rises on the following cycle.
- Spacing guarantee: from TT's result strobe to the next tt_in_valid there are at least 2 cycles (RESP then COLLECT), so TT is back in standby before the next burst.
- Throughput: a single-beat query with res_ready tied high takes ≥ 4 + TT latency cycles from wr_last to the next wr_ready.

Test Plan:
1. Path query: beats {0x03, 0x01, 0x12, 0x23} with last on beat 3; TT model returns cost 3 → tt_in_valid high for exactly 4 contiguous cycles, tt_source/tt_destination = (0,3), (0,1), (1,2), (2,3); res_cost=3, res_qid=0, res_trunc=0, res_timeout=0.
2. Backpressure: host holds res_ready=0 for 10 cycles → res_valid and all result fields stable; wr_ready=0 throughout; after the accept, wr_ready=1 one cycle later and the next result carries res_qid=1.
3. Overflow: DEPTH=32 and a 40-beat query → burst is exactly 32 cycles of beats 0..31, with no gap; res_trunc=1.
4. Timeout: TT model never strobes → res_valid asserts with res_cost=0, res_timeout=1, TIMEOUT+1 cycles after tt_in_valid falls.
5. Reset mid-burst: assert rst at burst cycle 2 → tt_in_valid=0 in the same cycle; after release wr_ready=1, no residual burst, res_qid=0.
6. qid wrap and spacing: run 257 single-beat queries (wr_data=0x55) → res_qid wraps 255→0; every gap from tt_out_valid to the next tt_in_valid is ≥ 2 cycles.
